// File: rtl/board_uart_tx.sv
// board_uart_tx: snapshots the 3x3 board, winner and current player on a
// send request and transmits it as a fixed UART 8N1 frame:
//   HEADER, 9 cell glyphs (row-major), status, XOR checksum.
// Optional macro BOARD_TX_CRLF_EN appends CR, LF after the checksum.
module board_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send,
    input  logic [3:1][3:1][1:0]  board,
    input  logic [1:0]            winner,
    input  logic [1:0]            current_player,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Index of the final byte of the frame; the checksum is always byte 11.
`ifdef BOARD_TX_CRLF_EN
    localparam logic [3:0] LAST_BYTE = 4'd13;
`else
    localparam logic [3:0] LAST_BYTE = 4'd11;
`endif
    localparam logic [3:0] CSUM_BYTE = 4'd11;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             bit_idx;
    logic [3:0]             byte_idx;
    logic [3:1][3:1][1:0]   snap_board;
    logic [1:0]             snap_winner;
    logic [1:0]             snap_player;
    logic [7:0]             csum;
    logic [7:0]             cur_byte;
    logic                   accept;
    logic                   bit_end;

    assign accept  = (state == IDLE) && send;
    assign bit_end = (bit_cnt == BIT_LAST);

    function automatic logic [7:0] cell_glyph(input logic [1:0] code);
        case (code)
            2'd0:    return 8'h2E;  // '.'
            2'd1:    return 8'h58;  // 'X'
            2'd2:    return 8'h4F;  // 'O'
            default: return 8'h3F;  // '?'
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and line outputs; tx/busy/done are pure decodes of state
    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (send) state_nxt = START;
            end
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx   = cur_byte[bit_idx];
                busy = 1'b1;
                if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                busy = 1'b1;
                if (bit_end) state_nxt = (byte_idx == LAST_BYTE) ? DONE : START;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-time, bit-index and byte-index counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            if (state == START || state == DATA || state == STOP)
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            else
                bit_cnt <= '0;
            // Wraps 7 -> 0 on its own, so it is ready for the next byte
            if (state == DATA && bit_end)
                bit_idx <= bit_idx + 3'd1;
            if (accept)
                byte_idx <= '0;
            else if (state == STOP && bit_end)
                byte_idx <= byte_idx + 4'd1;
        end
    end

    // Snapshot capture on accept; frozen for the rest of the frame
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_board  <= '0;
            snap_winner <= '0;
            snap_player <= '0;
        end else if (accept) begin
            snap_board  <= board;
            snap_winner <= winner;
            snap_player <= current_player;
        end
    end

    // Running checksum: folds in each byte as its stop bit completes
    always_ff @(posedge clk) begin
        if (!rst)
            csum <= '0;
        else if (accept)
            csum <= '0;
        else if (state == STOP && bit_end && byte_idx < CSUM_BYTE)
            csum <= csum ^ cur_byte;
    end

    // Byte currently on the wire, selected by byte index
    always_comb begin
        cur_byte = 8'hFF;
        case (byte_idx)
            4'd0:  cur_byte = HEADER;
            4'd1:  cur_byte = cell_glyph(snap_board[1][1]);
            4'd2:  cur_byte = cell_glyph(snap_board[1][2]);
            4'd3:  cur_byte = cell_glyph(snap_board[1][3]);
            4'd4:  cur_byte = cell_glyph(snap_board[2][1]);
            4'd5:  cur_byte = cell_glyph(snap_board[2][2]);
            4'd6:  cur_byte = cell_glyph(snap_board[2][3]);
            4'd7:  cur_byte = cell_glyph(snap_board[3][1]);
            4'd8:  cur_byte = cell_glyph(snap_board[3][2]);
            4'd9:  cur_byte = cell_glyph(snap_board[3][3]);
            4'd10: cur_byte = {2'b00, snap_winner, 2'b00, snap_player};
            4'd11: cur_byte = csum;
`ifdef BOARD_TX_CRLF_EN
            4'd12: cur_byte = 8'h0D;
            4'd13: cur_byte = 8'h0A;
`endif
            default: cur_byte = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_board_uart_tx.sv
// Testbench for board_uart_tx: a UART receiver decodes tx and checks each
// byte against a queue filled by a frame-level reference model when a
// request is issued; the main process checks handshake timing.
module tb_board_uart_tx;

    localparam int CPB = 4;
`ifdef BOARD_TX_CRLF_EN
    localparam int NBYTES = 14;
`else
    localparam int NBYTES = 12;
`endif
    localparam int FRAME_CYC = NBYTES * 10 * CPB;

    typedef logic [3:1][3:1][1:0] brd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    brd_t       board = '0;
    logic [1:0] winner = '0;
    logic [1:0] current_player = '0;
    logic       tx, busy, done;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q[$];

    board_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .send(send), .board(board), .winner(winner),
        .current_player(current_player), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: whole frame from the spec's byte rules
    task automatic push_expected(input brd_t b, input logic [1:0] w, input logic [1:0] cp);
        logic [7:0] glyph [4] = '{8'h2E, 8'h58, 8'h4F, 8'h3F};
        logic [7:0] bytes[$];
        logic [7:0] x;
        bytes.push_back(8'hA5);
        for (int r = 1; r <= 3; r++)
            for (int c = 1; c <= 3; c++)
                bytes.push_back(glyph[b[r][c]]);
        bytes.push_back({2'b00, w, 2'b00, cp});
        x = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];
        bytes.push_back(x);
`ifdef BOARD_TX_CRLF_EN
        bytes.push_back(8'h0D);
        bytes.push_back(8'h0A);
`endif
        foreach (bytes[i]) exp_q.push_back(bytes[i]);
    endtask

    // UART receiver: samples near mid-bit, compares with the scoreboard
    initial begin
        logic [7:0] rx;
        logic       st, sp;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            sp = tx;
            if (mon_en) begin
                check("start_bit", st, 1'b0);
                check("stop_bit", sp, 1'b1);
                if (exp_q.size() == 0)
                    check("unexpected_byte", rx, 32'hDEAD);
                else
                    check("frame_byte", rx, exp_q.pop_front());
            end
        end
    end

    task automatic run_frame(input brd_t b, input logic [1:0] w, input logic [1:0] cp,
                             input bit disturb);
        int cyc;
        int dones;
        @(negedge clk);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", busy, 1'b0);
        board = b; winner = w; current_player = cp; send = 1'b1;
        push_expected(b, w, cp);
        @(negedge clk);
        send = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_tx_low", tx, 1'b0);
        cyc = 1;
        dones = 0;
        while (busy && cyc < FRAME_CYC + 20) begin
            // Late request with a changed board must not affect this frame
            if (disturb && cyc == 40) begin
                board[3][3] = 2'd2;
                send = 1'b1;
            end else begin
                send = 1'b0;
            end
            @(negedge clk);
            if (done) dones++;
            if (busy) cyc++;
        end
        check("busy_cycles", cyc, FRAME_CYC);
        check("done_count", dones, 1);
        check("done_pulse", done, 1'b1);
        check("done_tx", tx, 1'b1);
        // Request during DONE is dropped
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("done_send_ignored", busy, 1'b0);
        check("done_low", done, 1'b0);
        check("post_tx", tx, 1'b1);
        repeat (2) @(negedge clk);
        check("bytes_left", exp_q.size(), 0);
    endtask

    task automatic run_abort(input brd_t b);
        mon_en = 1'b0;
        @(negedge clk);
        board = b; winner = 2'd1; current_player = 2'd2; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (99) @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (60) @(negedge clk);
        check("abort_tx_idle", tx, 1'b1);
        mon_en = 1'b1;
    endtask

    initial begin
        brd_t b;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;

        // Empty board, P1 to move
        run_frame('0, 2'd0, 2'd1, 1'b0);

        // X at (1,1), O at (2,2), P1 won, then a late request mid-frame
        b = '0; b[1][1] = 2'd1; b[2][2] = 2'd2;
        run_frame(b, 2'd1, 2'd2, 1'b1);

        // Abort mid-frame, then a full frame must follow cleanly
        run_abort(b);
        run_frame(b, 2'd1, 2'd2, 1'b0);

        // All invalid codes
        b = '1;
        run_frame(b, 2'd3, 2'd3, 1'b0);

        // Random boards
        for (int n = 0; n < 5; n++) begin
            for (int r = 1; r <= 3; r++)
                for (int c = 1; c <= 3; c++)
                    b[r][c] = 2'($urandom_range(0, 3));
            run_frame(b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
